// File: rtl/fp_div_sqrt_result_conv_if.sv
// Handshake bundle between the divide/sqrt unit, the result converter
// and writeback: flopoco results in, IEEE-754 results with flags out.
interface fp_div_sqrt_result_conv_if #(
    parameter int ID_WIDTH = 3
);
    logic                in_done;
    logic [ID_WIDTH-1:0] in_id;
    logic [33:0]         in_rd;
    logic                in_ack;
    logic                out_valid;
    logic [ID_WIDTH-1:0] out_id;
    logic [31:0]         out_rd;
    logic [4:0]          out_fflags;
    logic                out_ack;

    // Producer/consumer side: drives the flopoco result and the writeback ack.
    modport master (
        output in_done, in_id, in_rd, out_ack,
        input  in_ack, out_valid, out_id, out_rd, out_fflags
    );

    // Converter side: accepts results and presents the converted head entry.
    modport slave (
        input  in_done, in_id, in_rd, out_ack,
        output in_ack, out_valid, out_id, out_rd, out_fflags
    );
endinterface

// File: rtl/fp_div_sqrt_result_conv.sv
// Converts flopoco results from the divide/sqrt unit into IEEE-754 singles
// with exception flags and buffers them in a small FIFO so the pipeline is
// not stalled by writeback arbitration. Conversion happens at push time, so
// the outputs come straight from storage with no input-to-output path.
module fp_div_sqrt_result_conv #(
    parameter int DEPTH    = 2,
    parameter int ID_WIDTH = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    output logic [$clog2(DEPTH):0]  count_o,
    fp_div_sqrt_result_conv_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0]    wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]    rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ID_WIDTH-1:0] idMem_q   [DEPTH];
    logic [31:0]         dataMem_q [DEPTH];
    logic [4:0]          flagMem_q [DEPTH];

    logic                inAck;
    logic                outValid;
    logic                push;
    logic                pop;
    logic [31:0]         convRd;
    logic [4:0]          convFlags;
    logic                inSign;
    logic [7:0]          inExp;

    assign inSign   = bus.in_rd[31];
    assign inExp    = bus.in_rd[30:23];

    // A full FIFO may still accept when writeback frees the head this cycle.
    assign inAck    = !flush_i && ((count_q < CNT_W'(DEPTH)) || bus.out_ack);
    assign outValid = (count_q != '0);
    assign push     = bus.in_done && inAck;
    assign pop      = outValid && bus.out_ack;

    assign bus.in_ack     = inAck;
    assign bus.out_valid  = outValid;
    assign bus.out_id     = idMem_q[rdPtr_q];
    assign bus.out_rd     = dataMem_q[rdPtr_q];
    assign bus.out_fflags = flagMem_q[rdPtr_q];
    assign count_o        = count_q;

    // Flopoco-to-IEEE conversion; subnormal-range results flush to zero and
    // exponent 255 overflows to infinity, NaNs become the canonical quiet NaN.
    always_comb begin
        convRd    = 32'h0;
        convFlags = 5'b00000;
        case (bus.in_rd[33:32])
            2'b00: convRd = {inSign, 31'b0};
            2'b01: begin
                if (inExp == 8'h00) begin
                    convRd    = {inSign, 31'b0};
                    convFlags = 5'b00011;
                end else if (inExp == 8'hFF) begin
                    convRd    = {inSign, 8'hFF, 23'b0};
                    convFlags = 5'b00101;
                end else begin
                    convRd    = {inSign, bus.in_rd[30:0]};
                end
            end
            2'b10: convRd = {inSign, 8'hFF, 23'b0};
            default: convRd = 32'h7FC00000;
        endcase
    end

    // Pointer and occupancy next-state; flush wins over any push or pop.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (push) wrPtr_d = wrPtr_q + PTR_W'(1);
            if (pop)  rdPtr_d = rdPtr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Entry storage, written with the already-converted result on push.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                idMem_q[i]   <= '0;
                dataMem_q[i] <= '0;
                flagMem_q[i] <= '0;
            end
        end else if (push) begin
            idMem_q[wrPtr_q]   <= bus.in_id;
            dataMem_q[wrPtr_q] <= convRd;
            flagMem_q[wrPtr_q] <= convFlags;
        end
    end

endmodule

// File: tb/tb_fp_div_sqrt_result_conv.sv
// Self-checking bench for the result converter: directed scenarios plus a
// randomized stream, all compared against a queue-based reference model.
module tb_fp_div_sqrt_result_conv;

    localparam int DEPTH    = 2;
    localparam int ID_WIDTH = 3;

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [31:0]         rd;
        logic [4:0]          fl;
    } entry_t;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic [1:0] count;

    int assertCount = 0;
    int failCount   = 0;
    bit lastPush    = 0;
    entry_t modelQ[$];

    fp_div_sqrt_result_conv_if #(.ID_WIDTH(ID_WIDTH)) bus ();

    fp_div_sqrt_result_conv #(
        .DEPTH   (DEPTH),
        .ID_WIDTH(ID_WIDTH)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .flush_i(flush),
        .count_o(count),
        .bus    (bus)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Drives one cycle's worth of inputs.
    task automatic applyStimulus(input logic done, input logic [ID_WIDTH-1:0] id,
                                 input logic [33:0] rd, input logic outAck,
                                 input logic fl);
        bus.in_done = done;
        bus.in_id   = id;
        bus.in_rd   = rd;
        bus.out_ack = outAck;
        flush       = fl;
    endtask

    // Reference conversion written straight from the value-class rules.
    function automatic entry_t refEntry(input logic [ID_WIDTH-1:0] id,
                                        input logic [33:0] rd);
        entry_t e;
        logic [31:0] signedZero;
        logic [31:0] signedInf;
        signedZero = rd[31] ? 32'h80000000 : 32'h00000000;
        signedInf  = rd[31] ? 32'hFF800000 : 32'h7F800000;
        e.id = id;
        e.fl = 5'd0;
        case (rd[33:32])
            2'b00: e.rd = signedZero;
            2'b10: e.rd = signedInf;
            2'b11: e.rd = 32'h7FC00000;
            default: begin
                if (rd[30:23] == 8'd0) begin
                    e.rd = signedZero;
                    e.fl = 5'b00011;
                end else if (rd[30:23] == 8'd255) begin
                    e.rd = signedInf;
                    e.fl = 5'b00101;
                end else begin
                    e.rd = rd[31:0];
                end
            end
        endcase
        return e;
    endfunction

    // Random flopoco operand biased toward the exponent boundaries.
    function automatic logic [33:0] randRd();
        logic [1:0] exn;
        logic [7:0] ex;
        exn = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
            0:       ex = 8'h00;
            1:       ex = 8'hFF;
            default: ex = 8'($urandom);
        endcase
        return {exn, 1'($urandom), ex, 23'($urandom)};
    endfunction

    // One clock: check outputs mid-cycle against the model, then advance the
    // model at the rising edge using its own idea of whether input was taken.
    task automatic tick();
        logic   ackExp;
        entry_t head;
        @(negedge clk);
        ackExp = !flush && ((modelQ.size() < DEPTH) || bus.out_ack);
        if (rst_n) begin
            checkOutput("in_ack", 64'(bus.in_ack), 64'(ackExp));
            checkOutput("out_valid", 64'(bus.out_valid), 64'(modelQ.size() != 0));
            checkOutput("count", 64'(count), 64'(modelQ.size()));
            if (modelQ.size() != 0) begin
                head = modelQ[0];
                checkOutput("out_id", 64'(bus.out_id), 64'(head.id));
                checkOutput("out_rd", 64'(bus.out_rd), 64'(head.rd));
                checkOutput("out_fflags", 64'(bus.out_fflags), 64'(head.fl));
            end
        end
        @(posedge clk);
        lastPush = 1'b0;
        if (rst_n) begin
            if (flush) begin
                modelQ.delete();
            end else begin
                if (bus.out_ack && modelQ.size() != 0) void'(modelQ.pop_front());
                if (bus.in_done && ackExp) begin
                    modelQ.push_back(refEntry(bus.in_id, bus.in_rd));
                    lastPush = 1'b1;
                end
            end
        end
        #1;
    endtask

    // Scenario sequence.
    initial begin
        int n;
        int guard;
        rst_n = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        #3;
        checkOutput("rst_count", 64'(count), 64'd0);
        checkOutput("rst_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_rd", 64'(bus.out_rd), 64'd0);
        checkOutput("rst_id", 64'(bus.out_id), 64'd0);
        checkOutput("rst_fflags", 64'(bus.out_fflags), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;

        $display("[TB] single push");
        applyStimulus(1'b1, 3'd5, {2'b01, 1'b0, 8'h80, 23'h400000}, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        checkOutput("t1_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("t1_rd", 64'(bus.out_rd), 64'h40400000);
        checkOutput("t1_id", 64'(bus.out_id), 64'd5);
        checkOutput("t1_fflags", 64'(bus.out_fflags), 64'd0);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        checkOutput("t1_drained", 64'(bus.out_valid), 64'd0);

        $display("[TB] special values");
        applyStimulus(1'b1, 3'd1, {2'b00, 1'b1, 31'h12345}, 1'b1, 1'b0);
        tick();
        checkOutput("t2_negzero", 64'(bus.out_rd), 64'h80000000);
        applyStimulus(1'b1, 3'd2, {2'b10, 1'b0, 31'h55}, 1'b1, 1'b0);
        tick();
        checkOutput("t2_inf", 64'(bus.out_rd), 64'h7F800000);
        applyStimulus(1'b1, 3'd3, {2'b11, 1'b1, 31'h7ABCDEF}, 1'b1, 1'b0);
        tick();
        checkOutput("t2_nan", 64'(bus.out_rd), 64'h7FC00000);
        applyStimulus(1'b1, 3'd4, {2'b01, 1'b0, 8'h00, 23'h1234}, 1'b1, 1'b0);
        tick();
        checkOutput("t2_uf_rd", 64'(bus.out_rd), 64'h0);
        checkOutput("t2_uf_fl", 64'(bus.out_fflags), 64'b00011);
        applyStimulus(1'b1, 3'd5, {2'b01, 1'b1, 8'hFF, 23'h1}, 1'b1, 1'b0);
        tick();
        checkOutput("t2_of_rd", 64'(bus.out_rd), 64'hFF800000);
        checkOutput("t2_of_fl", 64'(bus.out_fflags), 64'b00101);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        tick();

        $display("[TB] backpressure");
        applyStimulus(1'b1, 3'd1, randRd(), 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 3'd2, randRd(), 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 3'd3, randRd(), 1'b0, 1'b0);
        checkOutput("t3_full_count", 64'(count), 64'd2);
        checkOutput("t3_full_ack", 64'(bus.in_ack), 64'd0);
        tick();
        bus.out_ack = 1'b1;
        #1;
        checkOutput("t3_ack_on_pop", 64'(bus.in_ack), 64'd1);
        tick();
        checkOutput("t3_count_hold", 64'(count), 64'd2);
        checkOutput("t3_head", 64'(bus.out_id), 64'd2);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        checkOutput("t3_last", 64'(bus.out_id), 64'd3);
        tick();

        $display("[TB] pointer wrap");
        n = 0;
        guard = 0;
        while (n < 10 && guard < 60) begin
            applyStimulus(1'b1, 3'(n % 8), randRd(), 1'(guard % 2 == 0), 1'b0);
            tick();
            if (lastPush) n++;
            guard++;
        end
        checkOutput("t4_all_pushed", 64'(n), 64'd10);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        repeat (3) tick();

        $display("[TB] flush");
        applyStimulus(1'b1, 3'd6, randRd(), 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 3'd7, randRd(), 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 3'd1, randRd(), 1'b1, 1'b1);
        checkOutput("t5_flush_ack", 64'(bus.in_ack), 64'd0);
        tick();
        checkOutput("t5_count", 64'(count), 64'd0);
        checkOutput("t5_valid", 64'(bus.out_valid), 64'd0);
        applyStimulus(1'b1, 3'd4, randRd(), 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        checkOutput("t5_first_id", 64'(bus.out_id), 64'd4);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        tick();

        $display("[TB] async reset");
        applyStimulus(1'b1, 3'd2, randRd(), 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        checkOutput("t6_pre_count", 64'(count), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("t6_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("t6_count", 64'(count), 64'd0);
        checkOutput("t6_ack", 64'(bus.in_ack), 64'd1);
        modelQ.delete();
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b1, 3'd3, randRd(), 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        repeat (2) tick();

        $display("[TB] random stream");
        for (int c = 0; c < 400; c++) begin
            applyStimulus(1'($urandom_range(0, 9) < 7), 3'($urandom), randRd(),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));
            tick();
        end
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/fp_div_sqrt_result_conv.md
Name: fp_div_sqrt_result_conv

Overview:
- Sits directly downstream of the single-precision FP divide/sqrt unit and consumes its flopoco-format result (done/id/rd/ack handshake).
- Converts the 34-bit flopoco value to a 32-bit IEEE-754 single.
- Generates conversion exception flags.
- Buffers results in a small FIFO so the divide/sqrt pipeline is not stalled by writeback arbitration.

Parameters:
- DEPTH, 2, number of FIFO entries. Power of two, >= 2.
- ID_WIDTH, 3, width of the instruction id carried with each result.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous FIFO clear.
- in_done  in  1  upstream result valid.
- in_id  in  ID_WIDTH  upstream result id.
- in_rd  in  34  flopoco result. Bits [33:32] exn (00 zero, 01 normal, 10 inf, 11 NaN), [31] sign, [30:23] exponent, [22:0] fraction.
- in_ack  out  1  result accepted; upstream advances on in_done && in_ack.
- out_valid  out  1  converted result available.
- out_id  out  ID_WIDTH  id of head result.
- out_rd  out  32  IEEE-754 single result.
- out_fflags  out  5  {NV,DZ,OF,UF,NX} for the head result.
- out_ack  in  1  writeback consumed the head entry.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst=0, asynchronous) clears the following, holding while rst=0:
  - count, write pointer and read pointer cleared to 0;
  - every entry's id, data and flags cleared to 0;
  - out_valid=0, out_rd=0, out_id=0, out_fflags=0.
- Conversion is combinational on in_rd and is written into the FIFO entry at push time. Rules:
  - exn=00: {sign, 31'b0}, flags 0.
  - exn=01 with exponent in 1..254: {sign, exponent, fraction}, flags 0.
  - exn=01 with exponent=0: flush to {sign, 31'b0}, flags UF|NX (5'b00011).
  - exn=01 with exponent=255: {sign, 8'hFF, 23'b0}, flags OF|NX (5'b00101).
  - exn=10: {sign, 8'hFF, 23'b0}, flags 0.
  - exn=11: canonical NaN 32'h7FC00000, flags 0. NV and DZ are always 0 from this block.
- Push/pop qualifiers:
  - push = in_done && in_ack.
  - pop = out_valid && out_ack.
  - out_ack while out_valid=0 is ignored.
- in_ack = !flush && (count < DEPTH || out_ack). A full FIFO accepts in the same cycle it pops.
- out_valid = (count != 0). out_id/out_rd/out_fflags present the head entry directly from storage.
- Latency: a result pushed at edge N is visible with out_valid=1 after edge N (one cycle). No combinational in→out path.
- Count update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: count unchanged, both pointers advance.
  - neither: hold.
- Pointers wrap modulo DEPTH. Ordering is strictly FIFO by arrival.
- Full (count=DEPTH) with out_ack=0: in_ack=0, upstream stalls, entries unchanged.
- Empty with push: out_valid rises next cycle. No same-cycle bypass.
- Flush:
  - count and pointers are cleared to 0 at the next edge.
  - in_ack is forced to 0 during flush, so no push occurs.
  - A pop in the same cycle is discarded.
  - Entry contents are not cleared; out_valid=0 after the edge.
- Reset mid-operation: all buffered results are lost and in_ack is driven from count=0 immediately.
- An out_ack held high with no new pushes drains one entry per cycle.

Test Plan:
1. Reset then single push: in_rd={2'b01,1'b0,8'h80,23'h400000}, id=5 → one cycle later out_valid=1, out_rd=32'h40400000, out_id=5, out_fflags=0; out_ack → out_valid=0 next cycle.
2. Special values, one per cycle with out_ack=1:
   - exn=00 sign=1 → 32'h80000000;
   - exn=10 sign=0 → 32'h7F800000;
   - exn=11 → 32'h7FC00000;
   - exn=01 exp=0 → 32'h0, flags 5'b00011;
   - exn=01 exp=255 sign=1 → 32'hFF800000, flags 5'b00101.
3. Backpressure, out_ack=0, DEPTH=2: push ids 1 and 2 → count=2 and in_ack=0. Then raise out_ack together with in_done id=3 → push accepted, count stays 2. Drain order is 1, 2, 3.
4. Pointer wrap: stream 10 results, ids 0..9 mod 8, with out_ack toggling 1/0 → output order matches input order, count never exceeds 2, no loss or duplication.
5. Flush with count=2 and in_done=1 → in_ack=0 that cycle, count=0 and out_valid=0 next cycle; a subsequent push of id=4 appears first.
6. Assert rst=0 asynchronously mid-stream with count=1 → out_valid=0 and count=0 immediately, without waiting for a clock edge; normal operation resumes after release.
